// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
//
// Contents:
//   INSTR_W        width of an instruction word
//   INSTR_BYTES    fetch PC increment per instruction
//   fetch_entry_t  {pc, instr} pair for the default 32-bit PC build
//   cnt_width()    bits needed to count 0..depth
//   ptr_width()    bits needed to index 0..depth-1 (at least 1)
package pc_fetch_unit_pkg;

    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned INSTR_BYTES  = 4;
    localparam int unsigned DEFAULT_PC_W = 32;

    typedef struct packed {
        logic [DEFAULT_PC_W-1:0] pc;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_buffer.sv
// Small synchronous FIFO used for the instruction buffer and the in-flight PC queue.
//
// Parameters:
//   DEPTH    number of entries (>= 1); pointers wrap modulo DEPTH
//   entry_t  stored element type
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   flush              empty the FIFO this cycle (overrides push/pop)
//   push, push_data    write request and data
//   pop                advance the head
//   head               oldest entry (only meaningful when !empty)
//   full, empty        status
//   occupancy          number of valid entries
module fetch_buffer
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int unsigned PTR_W = ptr_width(DEPTH),
    localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] occupancy
);

    entry_t mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign occupancy = count_q;
    assign head      = mem[rd_ptr_q];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through the count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end. Owns the fetch PC, issues single-cycle fetch requests,
// tracks in-flight request PCs, buffers returned instructions with their PCs and
// presents the oldest to decode. Redirects flush the buffer and discard responses
// to requests already in flight.
//
// Optional build macro FETCH_PERF_COUNTERS_EN adds saturating performance counters
// FetchCount, DropCount_Total and StallCycles.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   PCNext           next fetch PC from the PC update handler
//   Redirect         control-flow change: flush buffer, drop in-flight responses
//   Stall            decode cannot accept an instruction
//   FetchPCp4        FetchPC + 4 (to the handler)
//   ImemReqValid/ImemReqReady/ImemReqAddr   fetch request handshake
//   ImemRespValid/ImemResp                  in-order instruction response
//   InstrValid_I/Instr_I/PC_I               buffer head to decode
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned          BIT_COUNT  = 32,
    parameter logic [BIT_COUNT-1:0] RESET_PC   = '0,
    parameter int unsigned          FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_COUNT-1:0] PCNext,
    input  logic                 Redirect,
    input  logic                 Stall,
    output logic [BIT_COUNT-1:0] FetchPCp4,
    output logic                 ImemReqValid,
    input  logic                 ImemReqReady,
    output logic [BIT_COUNT-1:0] ImemReqAddr,
    input  logic                 ImemRespValid,
    input  logic [INSTR_W-1:0]   ImemResp,
    output logic                 InstrValid_I,
    output logic [INSTR_W-1:0]   Instr_I,
    output logic [BIT_COUNT-1:0] PC_I
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [BIT_COUNT-1:0] FetchCount,
    output logic [BIT_COUNT-1:0] DropCount_Total,
    output logic [BIT_COUNT-1:0] StallCycles
`endif
);

    localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [BIT_COUNT-1:0] pc;
        logic [INSTR_W-1:0]   instr;
    } buf_entry_t;

    logic [BIT_COUNT-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]     outstanding_q, outstanding_d;
    logic [CNT_W-1:0]     drop_count_q, drop_count_d;

    logic [SUM_W-1:0]     in_use;
    logic                 credit;
    logic                 req_fire;
    logic                 resp_ok;
    logic                 resp_keep;
    logic                 buf_pop;

    buf_entry_t           buf_wdata;
    buf_entry_t           buf_head;
    logic                 buf_full;
    logic                 buf_empty;
    logic [CNT_W-1:0]     buf_occ;

    logic [BIT_COUNT-1:0] pcq_head;
    logic                 pcq_full;
    logic                 pcq_empty;
    logic [CNT_W-1:0]     pcq_occ;

    // Every request holds a credit from issue until its buffered entry is popped,
    // so outstanding + buffered never exceeds the buffer depth.
    assign in_use = SUM_W'(outstanding_q) + SUM_W'(buf_occ);
    assign credit = (in_use < SUM_W'(FIFO_DEPTH));

    assign ImemReqValid = credit && !Redirect && !reset;
    assign ImemReqAddr  = fetch_pc_q;
    assign FetchPCp4    = fetch_pc_q + BIT_COUNT'(INSTR_BYTES);
    assign req_fire     = ImemReqValid && ImemReqReady;

    // A response with nothing outstanding is spurious and ignored entirely.
    assign resp_ok   = ImemRespValid && (outstanding_q != '0);
    assign resp_keep = resp_ok && (drop_count_q == '0) && !Redirect;

    assign InstrValid_I = !buf_empty;
    assign buf_pop      = InstrValid_I && !Stall && !Redirect;
    assign Instr_I      = InstrValid_I ? buf_head.instr : '0;
    assign PC_I         = InstrValid_I ? buf_head.pc : '0;

    assign buf_wdata.pc    = pcq_head;
    assign buf_wdata.instr = ImemResp;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_ok);
        drop_count_d  = drop_count_q;

        if (req_fire || Redirect) fetch_pc_d = PCNext;

        // Everything in flight at a redirect belongs to the old path, except a
        // response arriving in that very cycle, which is consumed here.
        if (Redirect) begin
            drop_count_d = outstanding_q - CNT_W'(resp_ok);
        end else if (resp_ok && (drop_count_q != '0)) begin
            drop_count_d = drop_count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_count_q  <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
        end
    end

    // PCs of requests whose responses will be kept, oldest first.
    fetch_buffer #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (logic [BIT_COUNT-1:0])
    ) u_pc_queue (
        .clk       (clk),
        .rst       (reset),
        .flush     (Redirect),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (resp_keep),
        .head      (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .occupancy (pcq_occ)
    );

    fetch_buffer #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (buf_entry_t)
    ) u_instr_buf (
        .clk       (clk),
        .rst       (reset),
        .flush     (Redirect),
        .push      (resp_keep),
        .push_data (buf_wdata),
        .pop       (buf_pop),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .occupancy (buf_occ)
    );

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FetchCount      <= '0;
            DropCount_Total <= '0;
            StallCycles     <= '0;
        end else begin
            if (resp_keep && (FetchCount != '1)) begin
                FetchCount <= FetchCount + BIT_COUNT'(1);
            end
            if (resp_ok && !resp_keep && (DropCount_Total != '1)) begin
                DropCount_Total <= DropCount_Total + BIT_COUNT'(1);
            end
            if (InstrValid_I && Stall && (StallCycles != '1)) begin
                StallCycles <= StallCycles + BIT_COUNT'(1);
            end
        end
    end
`else
    // Performance counters compiled out; no extra state.
`endif

    // Spurious responses are tolerated by the logic but worth flagging.
    spurious_resp_a : assert property (@(posedge clk) disable iff (reset)
        !(ImemRespValid && (outstanding_q == '0)))
        else $warning("imem response with no request outstanding was ignored");

    // Each in-flight request is either tracked in the PC queue or pending discard.
    inflight_acct_a : assert property (@(posedge clk) disable iff (reset)
        SUM_W'(outstanding_q) == SUM_W'(pcq_occ) + SUM_W'(drop_count_q))
        else $error("in-flight accounting broken");

    buf_room_a : assert property (@(posedge clk) disable iff (reset)
        resp_keep |-> (!buf_full || buf_pop))
        else $error("instruction buffer overrun");

    pcq_room_a : assert property (@(posedge clk) disable iff (reset)
        req_fire |-> (!pcq_full || resp_keep))
        else $error("PC queue overrun");

    pcq_data_a : assert property (@(posedge clk) disable iff (reset)
        resp_keep |-> !pcq_empty)
        else $error("kept response without a tracked PC");

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam int unsigned BIT_COUNT  = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0100;
    localparam int unsigned FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCNext;
    logic        Redirect;
    logic        Stall;
    logic [31:0] FetchPCp4;
    logic        ImemReqValid;
    logic        ImemReqReady;
    logic [31:0] ImemReqAddr;
    logic        ImemRespValid;
    logic [31:0] ImemResp;
    logic        InstrValid_I;
    logic [31:0] Instr_I;
    logic [31:0] PC_I;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] FetchCount;
    logic [31:0] DropCount_Total;
    logic [31:0] StallCycles;
`endif

    pc_fetch_unit #(
        .BIT_COUNT  (BIT_COUNT),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .PCNext        (PCNext),
        .Redirect      (Redirect),
        .Stall         (Stall),
        .FetchPCp4     (FetchPCp4),
        .ImemReqValid  (ImemReqValid),
        .ImemReqReady  (ImemReqReady),
        .ImemReqAddr   (ImemReqAddr),
        .ImemRespValid (ImemRespValid),
        .ImemResp      (ImemResp),
        .InstrValid_I  (InstrValid_I),
        .Instr_I       (Instr_I),
        .PC_I          (PC_I)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .FetchCount      (FetchCount),
        .DropCount_Total (DropCount_Total),
        .StallCycles     (StallCycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] req_log[$];
    logic [31:0] pop_pc_log[$];
    logic [31:0] pop_instr_log[$];
    logic        pend_v;
    logic [31:0] pend_a;
    bit          auto_resp;
    bit          follow_p4;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic set_defaults();
        Redirect      = 1'b0;
        Stall         = 1'b0;
        ImemReqReady  = 1'b1;
        ImemRespValid = 1'b0;
        ImemResp      = '0;
        PCNext        = '0;
        auto_resp     = 1'b0;
        follow_p4     = 1'b1;
        pend_v        = 1'b0;
        pend_a        = '0;
        req_log.delete();
        pop_pc_log.delete();
        pop_instr_log.delete();
    endtask

    // Called at posedge+1; leaves inputs settled for the coming edge and logs traffic.
    task automatic settle();
        if (auto_resp) begin
            ImemRespValid = pend_v;
            ImemResp      = pend_v ? instr_of(pend_a) : 32'h0;
        end
        #1;
        if (follow_p4) PCNext = FetchPCp4;
        if (ImemReqValid && ImemReqReady) req_log.push_back(ImemReqAddr);
        if (InstrValid_I && !Stall && !Redirect) begin
            pop_pc_log.push_back(PC_I);
            pop_instr_log.push_back(Instr_I);
        end
        pend_v = ImemReqValid && ImemReqReady;
        pend_a = ImemReqAddr;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_defaults();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_defaults();
        #2;
        n_checks++; if (ImemReqValid !== 1'b0) begin n_fail++;
            $display("FAIL reset_reqvalid: got %b want 0", ImemReqValid); end
        n_checks++; if (InstrValid_I !== 1'b0) begin n_fail++;
            $display("FAIL reset_instrvalid: got %b want 0", InstrValid_I); end
        n_checks++; if (Instr_I !== 32'h0 || PC_I !== 32'h0) begin n_fail++;
            $display("FAIL reset_head: got instr %h pc %h want 0 0", Instr_I, PC_I); end
        n_checks++; if (ImemReqAddr !== 32'h100) begin n_fail++;
            $display("FAIL reset_addr: got %h want 00000100", ImemReqAddr); end
        n_checks++; if (FetchPCp4 !== 32'h104) begin n_fail++;
            $display("FAIL reset_p4: got %h want 00000104", FetchPCp4); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [6];
        exp_pc = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
        do_reset();
        auto_resp = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            advance();
        end
        n_checks++; if (req_log.size() < 6 || pop_pc_log.size() < 6) begin n_fail++;
            $display("FAIL stream_counts: got req %0d pop %0d want >=6 >=6",
                     req_log.size(), pop_pc_log.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++; if (req_log[i] !== exp_pc[i]) begin n_fail++;
                    $display("FAIL stream_req[%0d]: got %h want %h", i, req_log[i], exp_pc[i]); end
                n_checks++; if (pop_pc_log[i] !== exp_pc[i] ||
                                pop_instr_log[i] !== instr_of(exp_pc[i])) begin n_fail++;
                    $display("FAIL stream_pop[%0d]: got pc %h instr %h want %h %h", i,
                             pop_pc_log[i], pop_instr_log[i], exp_pc[i], instr_of(exp_pc[i]));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h100, 32'h104, 32'h108, 32'h10C};
        do_reset();
        auto_resp = 1'b1;
        Stall     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            if (c >= 3) begin
                n_checks++; if (ImemReqValid !== 1'b0 || ImemReqAddr !== 32'h108) begin
                    n_fail++;
                    $display("FAIL stall_hold c%0d: got valid %b addr %h want 0 00000108",
                             c, ImemReqValid, ImemReqAddr); end
                n_checks++; if (InstrValid_I !== 1'b1 || PC_I !== 32'h100) begin n_fail++;
                    $display("FAIL stall_head c%0d: got valid %b pc %h want 1 00000100",
                             c, InstrValid_I, PC_I); end
            end
            advance();
        end
        Stall = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            advance();
        end
        n_checks++; if (pop_pc_log.size() < 4 || req_log.size() < 4) begin n_fail++;
            $display("FAIL stall_counts: got pop %0d req %0d want >=4 >=4",
                     pop_pc_log.size(), req_log.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (pop_pc_log[i] !== exp_pc[i] || req_log[i] !== exp_pc[i]) begin
                    n_fail++;
                    $display("FAIL stall_order[%0d]: got pop %h req %h want %h", i,
                             pop_pc_log[i], req_log[i], exp_pc[i]); end
            end
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        follow_p4 = 1'b0;
        Redirect  = 1'b1;
        PCNext    = 32'h200;
        settle();
        n_checks++; if (ImemReqValid !== 1'b0) begin n_fail++;
            $display("FAIL redir_noreq: got %b want 0", ImemReqValid); end
        advance();
        Redirect  = 1'b0;
        follow_p4 = 1'b1;
        settle();
        n_checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h200) begin n_fail++;
            $display("FAIL redir_req0: got %b %h want 1 00000200", ImemReqValid, ImemReqAddr); end
        advance();
        settle();
        n_checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h204) begin n_fail++;
            $display("FAIL redir_req1: got %b %h want 1 00000204", ImemReqValid, ImemReqAddr); end
        advance();
        follow_p4 = 1'b0;
        Redirect  = 1'b1;
        PCNext    = 32'h400;
        settle();
        advance();
        Redirect      = 1'b0;
        follow_p4     = 1'b1;
        ImemRespValid = 1'b1;
        ImemResp      = instr_of(32'h200);
        settle();
        n_checks++; if (ImemReqValid !== 1'b0 || InstrValid_I !== 1'b0) begin n_fail++;
            $display("FAIL redir_drop0: got req %b valid %b want 0 0", ImemReqValid,
                     InstrValid_I); end
        advance();
        ImemResp = instr_of(32'h204);
        settle();
        n_checks++; if (InstrValid_I !== 1'b0) begin n_fail++;
            $display("FAIL redir_drop1: got valid %b want 0", InstrValid_I); end
        n_checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h400) begin n_fail++;
            $display("FAIL redir_newreq: got %b %h want 1 00000400", ImemReqValid,
                     ImemReqAddr); end
        advance();
        ImemResp = instr_of(32'h400);
        settle();
        n_checks++; if (InstrValid_I !== 1'b0) begin n_fail++;
            $display("FAIL redir_drop2: got valid %b want 0", InstrValid_I); end
        advance();
        ImemRespValid = 1'b0;
        settle();
        n_checks++; if (InstrValid_I !== 1'b1 || PC_I !== 32'h400 ||
                        Instr_I !== instr_of(32'h400)) begin n_fail++;
            $display("FAIL redir_first: got %b %h %h want 1 00000400 %h", InstrValid_I, PC_I,
                     Instr_I, instr_of(32'h400)); end
        advance();
    endtask

    task automatic test_redirect_with_resp();
        do_reset();
        settle();
        n_checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h100) begin n_fail++;
            $display("FAIL rwr_req: got %b %h want 1 00000100", ImemReqValid, ImemReqAddr); end
        advance();
        Redirect      = 1'b1;
        follow_p4     = 1'b0;
        PCNext        = 32'h300;
        ImemRespValid = 1'b1;
        ImemResp      = instr_of(32'h100);
        settle();
        n_checks++; if (ImemReqValid !== 1'b0) begin n_fail++;
            $display("FAIL rwr_noreq: got %b want 0", ImemReqValid); end
        advance();
        Redirect      = 1'b0;
        follow_p4     = 1'b1;
        ImemRespValid = 1'b0;
        settle();
        n_checks++; if (InstrValid_I !== 1'b0 || ImemReqValid !== 1'b1 ||
                        ImemReqAddr !== 32'h300) begin n_fail++;
            $display("FAIL rwr_next: got valid %b req %b addr %h want 0 1 00000300",
                     InstrValid_I, ImemReqValid, ImemReqAddr); end
        advance();
        ImemRespValid = 1'b1;
        ImemResp      = instr_of(32'h300);
        settle();
        advance();
        ImemRespValid = 1'b0;
        settle();
        n_checks++; if (InstrValid_I !== 1'b1 || PC_I !== 32'h300 ||
                        Instr_I !== instr_of(32'h300)) begin n_fail++;
            $display("FAIL rwr_kept: got %b %h %h want 1 00000300 %h", InstrValid_I, PC_I,
                     Instr_I, instr_of(32'h300)); end
        advance();
    endtask

    task automatic test_ready_low();
        do_reset();
        auto_resp    = 1'b1;
        ImemReqReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h100 ||
                            InstrValid_I !== 1'b0) begin n_fail++;
                $display("FAIL rdy_low c%0d: got req %b addr %h valid %b want 1 00000100 0", c,
                         ImemReqValid, ImemReqAddr, InstrValid_I); end
            advance();
        end
        ImemReqReady = 1'b1;
        settle();
        advance();
        settle();
        n_checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h104) begin n_fail++;
            $display("FAIL rdy_resume: got %b %h want 1 00000104", ImemReqValid, ImemReqAddr); end
        advance();
        settle();
        n_checks++; if (InstrValid_I !== 1'b1 || PC_I !== 32'h100) begin n_fail++;
            $display("FAIL rdy_head: got %b %h want 1 00000100", InstrValid_I, PC_I); end
        advance();
    endtask

    task automatic test_pc_wrap();
        do_reset();
        follow_p4 = 1'b0;
        Redirect  = 1'b1;
        PCNext    = 32'hFFFF_FFFC;
        settle();
        advance();
        Redirect  = 1'b0;
        follow_p4 = 1'b1;
        settle();
        n_checks++; if (ImemReqAddr !== 32'hFFFF_FFFC || FetchPCp4 !== 32'h0) begin n_fail++;
            $display("FAIL wrap_p4: got addr %h p4 %h want fffffffc 00000000", ImemReqAddr,
                     FetchPCp4); end
        advance();
        settle();
        n_checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h0) begin n_fail++;
            $display("FAIL wrap_next: got %b %h want 1 00000000", ImemReqValid, ImemReqAddr); end
        advance();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        auto_resp = 1'b1;
        Stall     = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            advance();
        end
        n_checks++; if (InstrValid_I !== 1'b1 || PC_I !== 32'h100) begin n_fail++;
            $display("FAIL rmid_pre: got %b %h want 1 00000100", InstrValid_I, PC_I); end
        reset = 1'b1;
        #1;
        n_checks++; if (InstrValid_I !== 1'b0 || PC_I !== 32'h0 || Instr_I !== 32'h0) begin
            n_fail++;
            $display("FAIL rmid_clear: got %b %h %h want 0 0 0", InstrValid_I, PC_I, Instr_I); end
        n_checks++; if (ImemReqValid !== 1'b0 || ImemReqAddr !== 32'h100) begin n_fail++;
            $display("FAIL rmid_req: got %b %h want 0 00000100", ImemReqValid, ImemReqAddr); end
        @(posedge clk);
        #1;
        reset         = 1'b0;
        Stall         = 1'b0;
        auto_resp     = 1'b0;
        ImemReqReady  = 1'b0;
        ImemRespValid = 1'b1;
        ImemResp      = 32'hDEAD_BEEF;
        settle();
        advance();
        ImemRespValid = 1'b0;
        settle();
        n_checks++; if (InstrValid_I !== 1'b0) begin n_fail++;
            $display("FAIL rmid_spurious: got valid %b want 0", InstrValid_I); end
        n_checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h100) begin n_fail++;
            $display("FAIL rmid_credit: got %b %h want 1 00000100", ImemReqValid, ImemReqAddr); end
        advance();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_flush();
        test_redirect_with_resp();
        test_ready_low();
        test_pc_wrap();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
